// File: rtl/axis_pkt_mux_pkg.sv
// Shared types and constants for the packet-boundary AXI4-Stream multiplexer.
package axis_pkt_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int unsigned ARB_EXT = 0;
  localparam int unsigned ARB_RR  = 1;

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational rotating-priority encoder: first requester after i_ptr, wrapping.
module axis_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [SEL_W-1:0]  o_grant,
  output logic              o_valid
);

  logic [SEL_W-1:0] w_cand;

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the nearest requester wins last.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned off = NUM_CH; off > 0; off--) begin
      w_cand = SEL_W'((32'(i_ptr) + off) % NUM_CH);
      if (i_req[w_cand]) begin
        o_grant = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_mux.sv
// N-to-1 AXI4-Stream mux that holds a grant for a whole packet, with a registered output stage.
module axis_pkt_mux
  import axis_pkt_mux_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned ARB_MODE = 1,
  localparam int unsigned SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] S_TDATA,
  input  logic [NUM_CH-1:0]        S_TVALID,
  input  logic [NUM_CH-1:0]        S_TLAST,
  output logic [NUM_CH-1:0]        S_TREADY,
  output logic [DATA_W-1:0]        M_TDATA,
  output logic                     M_TVALID,
  output logic                     M_TLAST,
  input  logic                     M_TREADY,
  output logic [SEL_W-1:0]         grant,
  output logic                     busy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SEL_W-1:0]  r_grant;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic [DATA_W-1:0] r_m_tdata;
  logic              r_m_tvalid;
  logic              r_m_tlast;

  logic [SEL_W-1:0]  w_rr_grant;
  logic              w_rr_valid;
  logic              w_ext_ok;
  logic              w_req_ok;
  logic [SEL_W-1:0]  w_req_ch;
  logic [DATA_W-1:0] w_data_g;
  logic              w_valid_g;
  logic              w_last_g;
  logic              w_ready_g;
  logic              w_xfer;

  generate
    if (ARB_MODE == ARB_RR) begin : g_rr
      axis_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
      ) u_arb (
        .i_req   (S_TVALID),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_valid (w_rr_valid)
      );
    end else begin : g_ext
      assign w_rr_grant = '0;
      assign w_rr_valid = 1'b0;
    end
  endgenerate

  // Out-of-range sel never matches a channel index, so it is ignored here.
  always_comb begin
    w_ext_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i) && S_TVALID[i]) w_ext_ok = 1'b1;
    end
  end

  assign w_req_ok = (ARB_MODE == ARB_RR) ? w_rr_valid : w_ext_ok;
  assign w_req_ch = (ARB_MODE == ARB_RR) ? w_rr_grant : sel;

  always_comb begin
    w_data_g  = '0;
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_grant == SEL_W'(i)) begin
        w_data_g  = S_TDATA[i*DATA_W +: DATA_W];
        w_valid_g = S_TVALID[i];
        w_last_g  = S_TLAST[i];
      end
    end
  end

  assign w_ready_g = (r_state == ST_LOCK) && (!r_m_tvalid || M_TREADY);
  assign w_xfer    = w_ready_g && w_valid_g;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req_ok)             w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_xfer && w_last_g)   w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    S_TREADY = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_ready_g && r_grant == SEL_W'(i)) S_TREADY[i] = 1'b1;
    end
  end

  assign busy     = (r_state == ST_LOCK);
  assign grant    = r_grant;
  assign M_TDATA  = r_m_tdata;
  assign M_TVALID = r_m_tvalid;
  assign M_TLAST  = r_m_tlast;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_grant  <= '0;
      r_rr_ptr <= SEL_W'(NUM_CH - 1);
    end else begin
      if (r_state == ST_IDLE && w_req_ok) r_grant <= w_req_ch;
      if (ARB_MODE == ARB_RR && w_xfer && w_last_g) r_rr_ptr <= r_grant;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_xfer) begin
      r_m_tdata  <= w_data_g;
      r_m_tlast  <= w_last_g;
      r_m_tvalid <= 1'b1;
    end else if (r_m_tvalid && M_TREADY) begin
      r_m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pkt_mux.sv
// Randomized scoreboard bench for axis_pkt_mux in round-robin and external-select configurations.
module tb_axis_pkt_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  sel;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast;
  logic        m_tready;

  logic [3:0] a_stready, b_stready;
  logic [7:0] a_mdata, b_mdata;
  logic       a_mvalid, b_mvalid, a_mlast, b_mlast, a_busy, b_busy;
  logic [1:0] a_grant, b_grant;

  logic [1:0]  c_sel, c_grant;
  logic [23:0] c_tdata;
  logic [2:0]  c_tvalid, c_tlast, c_stready;
  logic [7:0]  c_mdata;
  logic        c_mvalid, c_mlast, c_mready, c_busy;

  axis_pkt_mux #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(1)) u_rr (
    .ACLK(clk), .ARESETn(rst_n), .sel(sel), .S_TDATA(s_tdata), .S_TVALID(s_tvalid),
    .S_TLAST(s_tlast), .S_TREADY(a_stready), .M_TDATA(a_mdata), .M_TVALID(a_mvalid),
    .M_TLAST(a_mlast), .M_TREADY(m_tready), .grant(a_grant), .busy(a_busy));

  axis_pkt_mux #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(0)) u_ext (
    .ACLK(clk), .ARESETn(rst_n), .sel(sel), .S_TDATA(s_tdata), .S_TVALID(s_tvalid),
    .S_TLAST(s_tlast), .S_TREADY(b_stready), .M_TDATA(b_mdata), .M_TVALID(b_mvalid),
    .M_TLAST(b_mlast), .M_TREADY(m_tready), .grant(b_grant), .busy(b_busy));

  axis_pkt_mux #(.NUM_CH(3), .DATA_W(8), .ARB_MODE(0)) u_ext3 (
    .ACLK(clk), .ARESETn(rst_n), .sel(c_sel), .S_TDATA(c_tdata), .S_TVALID(c_tvalid),
    .S_TLAST(c_tlast), .S_TREADY(c_stready), .M_TDATA(c_mdata), .M_TVALID(c_mvalid),
    .M_TLAST(c_mlast), .M_TREADY(c_mready), .grant(c_grant), .busy(c_busy));

  bit use_b;
  logic [3:0] obs_stready;
  logic [7:0] obs_mdata;
  logic       obs_mvalid, obs_mlast, obs_busy;
  logic [1:0] obs_grant;
  assign obs_stready = use_b ? b_stready : a_stready;
  assign obs_mdata   = use_b ? b_mdata   : a_mdata;
  assign obs_mvalid  = use_b ? b_mvalid  : a_mvalid;
  assign obs_mlast   = use_b ? b_mlast   : a_mlast;
  assign obs_busy    = use_b ? b_busy    : a_busy;
  assign obs_grant   = use_b ? b_grant   : a_grant;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] src_data [4][64];
  bit         src_last [4][64];
  int         src_len  [4];
  int         src_rd   [4];
  logic [8:0] exp_q[$];
  int         grant_q[$];

  int         rdy_pct;
  bit         chk_bubble;
  int         stall_a5;
  bit         sel_switch;
  logic [1:0] sel_cfg;
  bit         lat_pend;
  logic [7:0] lat_data;
  logic       lat_last;
  bit         prev_busy;
  int         bub;

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_rd[i]  = 0;
    end
    exp_q.delete();
    grant_q.delete();
  endtask

  task automatic add_pkt(input int ch, input int len, input bit with_a5);
    for (int b = 0; b < len; b++) begin
      src_data[ch][src_len[ch]] = (with_a5 && b == len / 2) ? 8'hA5 : 8'($urandom_range(0, 164));
      src_last[ch][src_len[ch]] = (b == len - 1);
      src_len[ch]++;
    end
  endtask

  // Round-robin reference: sources stay valid while they hold data, so every
  // arbitration sees exactly the channels with packets left.
  task automatic build_rr_expect();
    int pos[4];
    int ptr;
    int c;
    bit any;
    bit fin;
    ptr = 3;
    for (int i = 0; i < 4; i++) pos[i] = 0;
    do begin
      any = 0;
      for (int k = 1; k <= 4 && !any; k++) begin
        c = (ptr + k) % 4;
        if (pos[c] < src_len[c]) begin
          fin = 0;
          while (!fin) begin
            exp_q.push_back({src_last[c][pos[c]], src_data[c][pos[c]]});
            fin = src_last[c][pos[c]];
            pos[c]++;
          end
          grant_q.push_back(c);
          ptr = c;
          any = 1;
        end
      end
    end while (any);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    sel      = '0;
    c_sel    = '0;
    c_tvalid = '0;
    c_tlast  = '0;
    c_tdata  = '0;
    c_mready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    lat_pend   = 0;
    prev_busy  = 0;
    bub        = 0;
    stall_a5   = 0;
    sel_switch = 0;
  endtask

  task automatic step();
    int acc;
    logic [8:0] e;
    @(negedge clk);
    if (sel_switch && src_rd[1] >= 3) sel_cfg = 2'd0;
    sel = sel_cfg;
    for (int ch = 0; ch < 4; ch++) begin
      if (src_rd[ch] < src_len[ch]) begin
        s_tvalid[ch]         = 1'b1;
        s_tdata[ch*8 +: 8]   = src_data[ch][src_rd[ch]];
        s_tlast[ch]          = src_last[ch][src_rd[ch]];
      end else begin
        s_tvalid[ch]         = 1'b0;
        s_tdata[ch*8 +: 8]   = 8'($urandom);
        s_tlast[ch]          = 1'($urandom);
      end
    end
    if (stall_a5 > 0 && obs_mvalid && obs_mdata == 8'hA5) begin
      m_tready = 1'b0;
      stall_a5--;
    end else begin
      m_tready = ($urandom_range(1, 100) <= rdy_pct);
    end
    #4;
    if (chk_bubble && bub != 0) begin
      n_vec++;
      if (obs_mvalid !== (bub == 2)) begin
        n_err++;
        $display("FAIL bubble: M_TVALID=%0b, required %0b", obs_mvalid, (bub == 2));
      end
      bub = (bub == 1) ? 2 : 0;
    end
    if (lat_pend) begin
      n_vec++;
      if (obs_mvalid !== 1'b1 || obs_mdata !== lat_data || obs_mlast !== lat_last) begin
        n_err++;
        $display("FAIL out_reg: valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                 obs_mvalid, obs_mdata, obs_mlast, lat_data, lat_last);
      end
    end
    if (obs_mvalid && !m_tready) begin
      n_vec++;
      if (obs_stready !== 4'b0000) begin
        n_err++;
        $display("FAIL stall_ready: S_TREADY=%b, required 0000", obs_stready);
      end
    end
    if (!obs_busy) begin
      n_vec++;
      if (obs_stready !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_ready: S_TREADY=%b, required 0000", obs_stready);
      end
    end
    if (obs_busy && !prev_busy) begin
      n_vec++;
      if (grant_q.size() == 0) begin
        n_err++;
        $display("FAIL grant_order: grant=%0d, required no new grant", obs_grant);
      end else begin
        acc = grant_q.pop_front();
        if (obs_grant !== 2'(acc)) begin
          n_err++;
          $display("FAIL grant_order: grant=%0d, required %0d", obs_grant, acc);
        end
      end
    end
    prev_busy = obs_busy;
    acc = -1;
    for (int ch = 0; ch < 4; ch++) if (s_tvalid[ch] && obs_stready[ch]) acc = ch;
    lat_pend = 0;
    if (acc >= 0) begin
      lat_pend = 1;
      lat_data = src_data[acc][src_rd[acc]];
      lat_last = src_last[acc][src_rd[acc]];
    end else if (obs_mvalid && !m_tready) begin
      lat_pend = 1;
      lat_data = obs_mdata;
      lat_last = obs_mlast;
    end
    if (obs_mvalid && m_tready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_beat: data=%02h last=%0b, required no beat", obs_mdata, obs_mlast);
      end else begin
        e = exp_q.pop_front();
        if ({obs_mlast, obs_mdata} !== e) begin
          n_err++;
          $display("FAIL out_beat: last=%0b data=%02h, required last=%0b data=%02h",
                   obs_mlast, obs_mdata, e[8], e[7:0]);
        end
        bub = !e[8] ? 2 : (exp_q.size() > 0 ? 1 : 0);
      end
    end
    if (acc >= 0) src_rd[acc]++;
  endtask

  task automatic run_until_done(input string name, input int max_cyc);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < max_cyc) begin
      step();
      cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (3) step();
    n_vec++;
    if (grant_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_grants: %0d grants missing, required 0", name, grant_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_tvalid = 4'hF;
    s_tdata  = $urandom;
    c_tvalid = 3'b111;
    m_tready = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if ({a_mdata, a_mvalid, a_mlast, a_stready, a_grant, a_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_rr: data=%02h valid=%0b last=%0b ready=%b grant=%0d busy=%0b, required all 0",
               a_mdata, a_mvalid, a_mlast, a_stready, a_grant, a_busy);
    end
    n_vec++;
    if ({b_mdata, b_mvalid, b_mlast, b_stready, b_grant, b_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_ext: data=%02h valid=%0b ready=%b grant=%0d busy=%0b, required all 0",
               b_mdata, b_mvalid, b_stready, b_grant, b_busy);
    end
    n_vec++;
    if ({c_mdata, c_mvalid, c_mlast, c_stready, c_grant, c_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_ext3: data=%02h valid=%0b ready=%b grant=%0d busy=%0b, required all 0",
               c_mdata, c_mvalid, c_stready, c_grant, c_busy);
    end
  endtask

  task automatic test_round_robin();
    use_b = 0;
    do_reset();
    clear_sources();
    for (int ch = 0; ch < 4; ch++) begin
      add_pkt(ch, 2, 0);
      add_pkt(ch, 2, 0);
    end
    build_rr_expect();
    rdy_pct    = 100;
    chk_bubble = 1;
    run_until_done("round_robin", 100);
    chk_bubble = 0;
  endtask

  task automatic test_rr_random();
    use_b = 0;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      clear_sources();
      for (int ch = 0; ch < 4; ch++) begin
        for (int p = 0; p < $urandom_range(0, 3); p++) add_pkt(ch, $urandom_range(1, 6), 0);
      end
      build_rr_expect();
      rdy_pct = 60;
      run_until_done("rr_random", 800);
    end
  endtask

  task automatic test_backpressure();
    use_b = 0;
    do_reset();
    clear_sources();
    add_pkt(1, 6, 1);
    add_pkt(2, 3, 0);
    build_rr_expect();
    rdy_pct  = 100;
    stall_a5 = 3;
    run_until_done("backpressure", 100);
    n_vec++;
    if (stall_a5 !== 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d stall cycles unused, required 0", stall_a5);
    end
  endtask

  task automatic test_single_beat();
    use_b = 0;
    do_reset();
    clear_sources();
    for (int p = 0; p < 3; p++) begin
      add_pkt(2, 1, 0);
      add_pkt(3, 1, 0);
    end
    build_rr_expect();
    rdy_pct    = 100;
    chk_bubble = 1;
    run_until_done("single_beat", 100);
    chk_bubble = 0;
  endtask

  task automatic test_packet_lock();
    use_b = 1;
    do_reset();
    clear_sources();
    add_pkt(1, 8, 0);
    add_pkt(0, 3, 0);
    for (int b = 0; b < 8; b++) exp_q.push_back({src_last[1][b], src_data[1][b]});
    for (int b = 0; b < 3; b++) exp_q.push_back({src_last[0][b], src_data[0][b]});
    grant_q.push_back(1);
    grant_q.push_back(0);
    sel_cfg    = 2'd1;
    sel_switch = 1;
    rdy_pct    = 100;
    run_until_done("packet_lock", 100);
    sel_switch = 0;
    use_b      = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    use_b = 0;
    do_reset();
    clear_sources();
    add_pkt(1, 8, 0);
    build_rr_expect();
    rdy_pct = 100;
    cyc = 0;
    while (src_rd[1] < 3 && cyc < 50) begin
      step();
      cyc++;
    end
    @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b1 || a_grant !== 2'd1) begin
      n_err++;
      $display("FAIL midpkt_lock: busy=%0b grant=%0d, required busy=1 grant=1", a_busy, a_grant);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_mvalid, a_stready, a_busy, a_grant} !== '0) begin
      n_err++;
      $display("FAIL midpkt_reset: valid=%0b ready=%b busy=%0b grant=%0d, required all 0",
               a_mvalid, a_stready, a_busy, a_grant);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (a_mvalid !== 1'b0) begin
        n_err++;
        $display("FAIL midpkt_held: M_TVALID=%0b, required 0", a_mvalid);
      end
    end
    s_tvalid = '0;
    clear_sources();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (a_mvalid !== 1'b0 || a_busy !== 1'b0) begin
        n_err++;
        $display("FAIL midpkt_drop: valid=%0b busy=%0b, required 0 0", a_mvalid, a_busy);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    c_sel    = 2'd3;
    c_tvalid = 3'b111;
    c_tdata  = 24'($urandom);
    c_tlast  = 3'b000;
    c_mready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({c_busy, c_stready, c_mvalid} !== 5'b0) begin
        n_err++;
        $display("FAIL sel_range: busy=%0b ready=%b valid=%0b, required 0 000 0", c_busy, c_stready, c_mvalid);
      end
    end
    c_sel = 2'd2;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (c_busy !== 1'b1 || c_grant !== 2'd2) begin
      n_err++;
      $display("FAIL sel_valid: busy=%0b grant=%0d, required busy=1 grant=2", c_busy, c_grant);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    use_b      = 0;
    rdy_pct    = 100;
    chk_bubble = 0;
    sel_switch = 0;
    sel_cfg    = 2'd0;
    stall_a5   = 0;
    s_tvalid   = '0;
    s_tlast    = '0;
    s_tdata    = '0;
    sel        = '0;
    m_tready   = 1'b0;
    c_sel      = '0;
    c_tvalid   = '0;
    c_tlast    = '0;
    c_tdata    = '0;
    c_mready   = 1'b0;
    clear_sources();
    #2;
    test_reset();
    test_round_robin();
    test_rr_random();
    test_backpressure();
    test_single_beat();
    test_packet_lock();
    test_reset_mid();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
